// File: rtl/rs232_pkg.sv
// Constants shared by the RS-232 frame receive and transmit paths.
package rs232_pkg;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_CMD  = 2'd1,
    ST_LEN  = 2'd2,
    ST_DATA = 2'd3
  } state_t;

  localparam logic [7:0] FRAME_START = 8'hFF;

  localparam logic [7:0] CMD_KEY  = 8'd0;
  localparam logic [7:0] CMD_SW   = 8'd1;
  localparam logic [7:0] CMD_ECHO = 8'd4;

endpackage

// File: rtl/rs232_idle_timer.sv
// Inter-byte idle timer: counts cycles while run is high, expires after TIMEOUT_CYCLES quiet cycles.
module rs232_idle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || !run) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + 1'b1;
    end
  end

  // A byte arriving on the expiry cycle wins over the timeout.
  assign expired = run && !clear && (count == LAST);

endmodule

// File: rtl/rs232_frame_decoder.sv
// Parses FF/cmd/len/data frames from the uart byte stream into command, length and LE data word.
// Optional inter-byte timeout is built when RS232_FRAME_TIMEOUT_EN is defined.
module rs232_frame_decoder
  import rs232_pkg::*;
#(
  parameter int unsigned MAX_LEN = 4
`ifdef RS232_FRAME_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 50000
`endif
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET_N,
  input  logic [7:0]           RX_DATA,
  input  logic                 RX_RECV,
  output logic [7:0]           FRM_CMD,
  output logic [7:0]           FRM_LEN,
  output logic [8*MAX_LEN-1:0] FRM_DATA,
  output logic                 FRM_VALID,
  output logic                 FRM_ERR,
  output logic [1:0]           DBG_STATE
);

  localparam int unsigned IW = $clog2(MAX_LEN + 1);
  localparam int unsigned DW = 8 * MAX_LEN;

  state_t          state, state_next;
  logic [7:0]      cmd_q, len_q;
  logic [DW-1:0]   data_q, data_merged;
  logic [IW-1:0]   idx_q;
  logic            publish, reject, last_byte, timeout;

  assign DBG_STATE = state;
  assign last_byte = ((8'(idx_q) + 8'd1) == len_q);

`ifdef RS232_FRAME_TIMEOUT_EN
  rs232_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (CLOCK_50),
    .rst_n  (RESET_N),
    .clear  (RX_RECV),
    .run    (state != ST_SYNC),
    .expired(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Shift register with the current byte merged in, so the last byte publishes on its own edge.
  always_comb begin
    data_merged = data_q;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if (idx_q == IW'(i)) data_merged[8*i +: 8] = RX_DATA;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state <= ST_SYNC;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    publish    = 1'b0;
    reject     = 1'b0;
    if (RX_RECV) begin
      case (state)
        ST_SYNC: if (RX_DATA == FRAME_START) state_next = ST_CMD;
        ST_CMD:  state_next = ST_LEN;
        ST_LEN: begin
          if (RX_DATA == 8'd0) begin
            publish    = 1'b1;
            state_next = ST_SYNC;
          end else if (32'(RX_DATA) > MAX_LEN) begin
            reject     = 1'b1;
            state_next = ST_SYNC;
          end else begin
            state_next = ST_DATA;
          end
        end
        ST_DATA: begin
          if (last_byte) begin
            publish    = 1'b1;
            state_next = ST_SYNC;
          end
        end
        default: state_next = ST_SYNC;
      endcase
    end else if (timeout) begin
      reject     = 1'b1;
      state_next = ST_SYNC;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cmd_q     <= '0;
      len_q     <= '0;
      data_q    <= '0;
      idx_q     <= '0;
      FRM_CMD   <= '0;
      FRM_LEN   <= '0;
      FRM_DATA  <= '0;
      FRM_VALID <= 1'b0;
      FRM_ERR   <= 1'b0;
    end else begin
      FRM_VALID <= publish;
      FRM_ERR   <= reject;
      if (RX_RECV) begin
        case (state)
          ST_CMD: cmd_q <= RX_DATA;
          ST_LEN: begin
            len_q  <= RX_DATA;
            data_q <= '0;
            idx_q  <= '0;
          end
          ST_DATA: begin
            data_q <= data_merged;
            idx_q  <= idx_q + 1'b1;
          end
          default: ;
        endcase
      end
      // All three outputs move together so downstream never sees a mixed frame.
      if (publish) begin
        FRM_CMD  <= cmd_q;
        FRM_LEN  <= (state == ST_LEN) ? RX_DATA : len_q;
        FRM_DATA <= (state == ST_LEN) ? '0 : data_merged;
      end
    end
  end

endmodule

// File: tb/tb_rs232_frame_decoder.sv
// Directed + randomised frame stimulus with an expected-frame queue checked on each FRM_VALID.
// Timeout scenarios are compiled in when RS232_FRAME_TIMEOUT_EN is defined.
module tb_rs232_frame_decoder;

  localparam int MAX_LEN = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_recv;
  logic [7:0]  frm_cmd, frm_len;
  logic [31:0] frm_data;
  logic        frm_valid, frm_err;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [47:0] exp_q[$];
  logic [7:0]  err_gap_q[$];
  logic [7:0]  seq[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

`ifdef RS232_FRAME_TIMEOUT_EN
  rs232_frame_decoder #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(16)) dut (
`else
  rs232_frame_decoder #(.MAX_LEN(MAX_LEN)) dut (
`endif
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .RX_DATA  (rx_data),
    .RX_RECV  (rx_recv),
    .FRM_CMD  (frm_cmd),
    .FRM_LEN  (frm_len),
    .FRM_DATA (frm_data),
    .FRM_VALID(frm_valid),
    .FRM_ERR  (frm_err),
    .DBG_STATE(dbg_state)
  );

  // ---------------- check helper ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_seq();
    foreach (seq[i]) begin
      @(negedge clk);
      rx_data = seq[i];
      rx_recv = 1'b1;
      @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_recv = 1'b0;
      rx_data = 8'($urandom_range(0, 255));
      @(posedge clk);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] c, input logic [7:0] l,
                               input logic [31:0] d);
    @(negedge clk);
    check({tag, "_cmd"},  64'(frm_cmd),  64'(c));
    check({tag, "_len"},  64'(frm_len),  64'(l));
    check({tag, "_data"}, 64'(frm_data), 64'(d));
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic        recv_d = 1'b0;
  logic        valid_d = 1'b0;
  int          ncyc = 0;
  int          last_recv_cyc = 0;
  logic [47:0] e;
  logic [7:0]  g;

  always @(posedge clk) recv_d <= rx_recv;

  always @(negedge clk) begin
    ncyc++;
    if (recv_d) last_recv_cyc = ncyc;
    if (frm_valid || frm_err) check("valid_err_exclusive", 64'(frm_valid & frm_err), 64'd0);
    if (frm_valid) begin
      check("valid_width", 64'(valid_d), 64'd0);
      check("valid_latency", 64'(ncyc - last_recv_cyc), 64'd0);
      check("valid_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("frame", 64'({frm_cmd, frm_len, frm_data}), 64'(e));
      end
    end
    if (frm_err) begin
      check("err_expected", 64'(err_gap_q.size() != 0), 64'd1);
      if (err_gap_q.size() != 0) begin
        g = err_gap_q.pop_front();
        check("err_latency", 64'(ncyc - last_recv_cyc), 64'(g));
      end
    end
    valid_d = frm_valid;
  end

  // ---------------- stimulus ----------------
  logic [7:0]  r_cmd, r_len, r_b;
  logic [31:0] r_data;

  initial begin
    rst_n   = 1'b0;
    rx_recv = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd",   64'(frm_cmd),   64'd0);
    check("rst_len",   64'(frm_len),   64'd0);
    check("rst_data",  64'(frm_data),  64'd0);
    check("rst_valid", 64'(frm_valid), 64'd0);
    check("rst_err",   64'(frm_err),   64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Good frame
    seq = {8'hFF, 8'h01, 8'h03, 8'h34, 8'h12, 8'h02};
    exp_q.push_back({8'h01, 8'h03, 32'h0002_1234});
    send_seq();
    idle(4);
    check_outputs("good_hold", 8'h01, 8'h03, 32'h0002_1234);

    // Resync past garbage, zero-length frame
    seq = {8'h00, 8'h55, 8'hFF, 8'h00, 8'h00};
    exp_q.push_back({8'h00, 8'h00, 32'h0});
    send_seq();
    idle(3);
    check_outputs("resync_hold", 8'h00, 8'h00, 32'h0);

    // Embedded 0xFF and back-to-back frames
    seq = {8'hFF, 8'hFF, 8'h02, 8'hFF, 8'hFF, 8'hFF, 8'h04, 8'h01, 8'hAA};
    exp_q.push_back({8'hFF, 8'h02, 32'h0000_FFFF});
    exp_q.push_back({8'h04, 8'h01, 32'h0000_00AA});
    send_seq();
    idle(3);

    // Length overflow keeps previous outputs
    seq = {8'hFF, 8'h01, 8'h05};
    err_gap_q.push_back(8'd0);
    send_seq();
    idle(3);
    check_outputs("ovf_hold", 8'h04, 8'h01, 32'h0000_00AA);
    seq = {8'hFF, 8'h00, 8'h00};
    exp_q.push_back({8'h00, 8'h00, 32'h0});
    send_seq();
    idle(3);

    // Maximum-length frame, then a few random frames
    seq = {8'hFF, 8'h04, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
    exp_q.push_back({8'h04, 8'h04, 32'h4433_2211});
    send_seq();
    idle(2);
    for (int k = 0; k < 4; k++) begin
      r_cmd  = 8'($urandom_range(0, 255));
      r_len  = 8'($urandom_range(1, MAX_LEN));
      r_data = '0;
      seq = {8'hFF, r_cmd, r_len};
      for (int i = 0; i < int'(r_len); i++) begin
        r_b = 8'($urandom_range(0, 255));
        seq.push_back(r_b);
        r_data[8*i +: 8] = r_b;
      end
      exp_q.push_back({r_cmd, r_len, r_data});
      send_seq();
      idle($urandom_range(1, 3));
    end

    // Reset mid-frame
    seq = {8'hFF, 8'h01, 8'h03, 8'h11};
    send_seq();
    @(negedge clk);
    rx_recv = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seq = {8'h22, 8'h33};
    send_seq();
    idle(4);
    check_outputs("midrst", 8'h00, 8'h00, 32'h0);
    check("midrst_state", 64'(dbg_state), 64'd0);

`ifdef RS232_FRAME_TIMEOUT_EN
    // Silence after a partial frame expires 16 cycles after the last byte
    seq = {8'hFF, 8'h01, 8'h02, 8'hAA};
    err_gap_q.push_back(8'd16);
    send_seq();
    idle(20);
    check("timeout_state", 64'(dbg_state), 64'd0);
    // Byte arriving on the expiry cycle completes the frame instead
    seq = {8'hFF, 8'h01, 8'h02, 8'hAA};
    send_seq();
    idle(15);
    seq = {8'hBB};
    exp_q.push_back({8'h01, 8'h02, 32'h0000_BBAA});
    send_seq();
    idle(20);
`else
    // Without the timer a truncated frame waits for its remaining bytes
    seq = {8'hFF, 8'h01, 8'h02, 8'hAA};
    send_seq();
    idle(30);
    check("wait_state", 64'(dbg_state), 64'd3);
    seq = {8'hBB};
    exp_q.push_back({8'h01, 8'h02, 32'h0000_BBAA});
    send_seq();
    idle(4);
`endif

    idle(5);
    check("exp_q_empty",   64'(exp_q.size()),     64'd0);
    check("err_q_empty",   64'(err_gap_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
